// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and constants for the multi-word add sequencer.
package multiword_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORDS_MIN = 2;
  localparam int WORDS_MAX = 16;

  // Width of the byte index register: clog2(n), at least one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 8; i++) begin
      if ((1 << w) < n) begin
        w = w + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_add8_slice.sv
// Combinational 8-bit adder slice; c7 exposes the carry into bit 7 for overflow detection.
module add8_slice
  import multiword_add_sequencer_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co,
  output logic       c7
);

  logic [7:0] low_s;

  assign low_s = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, ci};
  assign c7    = low_s[7];
  assign s     = {a[7] ^ b[7] ^ c7, low_s[6:0]};
  assign co    = (a[7] & b[7]) | (c7 & (a[7] ^ b[7]));

endmodule

// File: rtl/multiword_add_sequencer.sv
// Byte-serial WORDS x 8-bit adder sequencer with valid/ready request and result handshakes.
// Define ADD_OVF_EN to add the signed-overflow output ovf.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [8*WORDS-1:0] op_a,
  input  logic [8*WORDS-1:0] op_b,
  input  logic               c_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [8*WORDS-1:0] sum,
  output logic               c_out,
`ifdef ADD_OVF_EN
  output logic               ovf,
`endif
  output logic               busy
);

  localparam int W  = 8 * WORDS;
  localparam int IW = idx_width(WORDS);

  state_t          state_r;
  state_t          next_state_s;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            carry_r;
  logic [IW-1:0]   idx_r;
  logic            last_s;
  logic [7:0]      byte_sum_s;
  logic            byte_co_s;

  assign last_s      = (idx_r == IW'(WORDS - 1));
  assign start_ready = (state_r == IDLE);
  assign res_valid   = (state_r == DONE);
  assign busy        = (state_r != IDLE);

  // Operands are shifted down a byte per step, so the slice always sees byte idx in [7:0].
`ifdef ADD_OVF_EN
  logic byte_c7_s;
  add8_slice u_slice (
    .a  (a_r[7:0]),
    .b  (b_r[7:0]),
    .ci (carry_r),
    .s  (byte_sum_s),
    .co (byte_co_s),
    .c7 (byte_c7_s)
  );
`else
  logic byte_c7_unused;
  add8_slice u_slice (
    .a  (a_r[7:0]),
    .b  (b_r[7:0]),
    .ci (carry_r),
    .s  (byte_sum_s),
    .co (byte_co_s),
    .c7 (byte_c7_unused)
  );
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (start_valid) next_state_s = RUN;  else next_state_s = IDLE;
      RUN:     if (last_s)      next_state_s = DONE; else next_state_s = RUN;
      DONE:    if (res_ready)   next_state_s = IDLE; else next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath: capture on accept, one byte per RUN cycle, hold through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
`ifdef ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            a_r     <= op_a;
            b_r     <= op_b;
            carry_r <= c_in;
            idx_r   <= '0;
            sum     <= '0;
`ifdef ADD_OVF_EN
            ovf     <= 1'b0;
`endif
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx_r == IW'(k)) begin
              sum[k*8 +: 8] <= byte_sum_s;
            end
          end
          carry_r <= byte_co_s;
          a_r     <= a_r >> 4'd8;
          b_r     <= b_r >> 4'd8;
          if (last_s) begin
            c_out <= byte_co_s;
`ifdef ADD_OVF_EN
            ovf   <= byte_c7_s ^ byte_co_s;
`endif
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          carry_r <= carry_r;
        end
        default: begin
          carry_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (WORDS=4); ovf checks enabled with ADD_OVF_EN.
module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         c_in = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
`ifdef ADD_OVF_EN
  logic         ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .c_in        (c_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .c_out       (c_out),
`ifdef ADD_OVF_EN
    .ovf         (ovf),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t       m;
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    m.s  = full[W-1:0];
    m.c  = full[W];
    m.v  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return m;
  endfunction

  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input bit push);
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    c_in        = ci;
    if (push) sb.push_back(model(a, b, ci));
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit timeout);
    lat     = 0;
    timeout = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (res_valid === 1'b1) begin
        lat     = i;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got %h want 0", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out got %b want 0", c_out); end
  endtask

  task automatic test_basic(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int   lat;
    bit   to;
    exp_t e;
    send_op(a, b, ci, 1'b1);
    checks++; if (busy !== 1'b1 || start_ready !== 1'b0) begin errors++; $display("FAIL %s_busy got busy=%b start_ready=%b want 1/0", name, busy, start_ready); end
    wait_result(lat, to);
    e = sb.pop_front();
    checks++; if (to || lat != WORDS) begin errors++; $display("FAIL %s_latency got %0d (timeout=%0d) want %0d", name, lat, to, WORDS); end
    checks++; if (sum !== e.s) begin errors++; $display("FAIL %s_sum got %h want %h", name, sum, e.s); end
    checks++; if (c_out !== e.c) begin errors++; $display("FAIL %s_c_out got %b want %b", name, c_out, e.c); end
`ifdef ADD_OVF_EN
    checks++; if (ovf !== e.v) begin errors++; $display("FAIL %s_ovf got %b want %b", name, ovf, e.v); end
`endif
    release_result();
    checks++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL %s_release got start_ready=%b res_valid=%b want 1/0", name, start_ready, res_valid); end
  endtask

  task automatic test_backpressure();
    int   lat;
    bit   to;
    exp_t e1;
    exp_t e2;
    send_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1);
    wait_result(lat, to);
    e1 = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL bp_first_timeout got timeout want result"); end
    start_valid = 1'b1;
    op_a        = 32'hDEAD_BEEF;
    op_b        = 32'h2152_4111;
    c_in        = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (sum !== e1.s || res_valid !== 1'b1 || start_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got sum=%h rv=%b sr=%b want sum=%h rv=1 sr=0", i, sum, res_valid, start_ready, e1.s);
      end
    end
    sb.push_back(model(op_a, op_b, c_in));
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checks++; if (start_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle got sr=%b busy=%b want 1/0", start_ready, busy); end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept got busy=%b want 1", busy); end
    wait_result(lat, to);
    e2 = sb.pop_front();
    checks++; if (to || lat != WORDS) begin errors++; $display("FAIL bp_second_latency got %0d want %0d", lat, WORDS); end
    checks++; if (sum !== e2.s || c_out !== e2.c) begin errors++; $display("FAIL bp_second_result got %h/%b want %h/%b", sum, c_out, e2.s, e2.c); end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    send_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++; if (sum !== 32'h0000_6789) begin errors++; $display("FAIL midrun_partial got %h want 00006789", sum); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sum !== '0 || c_out !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrun_async_reset got sum=%h c=%b rv=%b busy=%b want all 0", sum, c_out, res_valid, busy);
    end
`ifdef ADD_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrun_reset_ovf got %b want 0", ovf); end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (start_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrun_after_release got sr=%b busy=%b want 1/0", start_ready, busy); end
    test_basic("post_reset", 32'h0000_0001, 32'h0000_0002, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    for (int n = 0; n < 6; n++) begin
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom_range(1, 0));
      test_basic("b2b", a, b, ci);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0);
    test_basic("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef ADD_OVF_EN
    test_basic("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    test_basic("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0);
`endif
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d entries want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
